// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - locks onto a 4-bit x^4+x^3+1 LFSR stream, predicts each word, counts mispredictions.
// Define LFSR_CHK_PERIOD_EN to add period_tick, which pulses each time the lock word recurs.
module lfsr_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_word,
  input  logic             clr,
`ifdef LFSR_CHK_PERIOD_EN
  output logic             period_tick,
`endif
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       pred_q, pred_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       miss_q, miss_d;
  logic             locked_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_hit;
  logic             match;
`ifdef LFSR_CHK_PERIOD_EN
  logic [3:0]       anchor_q, anchor_d;
  logic             tick_q, tick_d;
`endif

  assign match = (in_word == pred_q);

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    run_d   = run_q;
    miss_d  = miss_q;
    err_hit = 1'b0;
`ifdef LFSR_CHK_PERIOD_EN
    anchor_d = anchor_q;
    tick_d   = 1'b0;
`endif
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_word != 4'd0) begin
            pred_d  = lfsr_next(in_word);
            run_d   = 4'd0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            pred_d = lfsr_next(pred_q);
            run_d  = run_q + 4'd1;
            if (run_q + 4'd1 == 4'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
`ifdef LFSR_CHK_PERIOD_EN
              anchor_d = in_word;
`endif
            end
          end else if (in_word != 4'd0) begin
            pred_d = lfsr_next(in_word);
            run_d  = 4'd0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: a bad word never reseeds, the prediction just advances.
          pred_d = lfsr_next(pred_q);
          if (match) begin
            miss_d = 4'd0;
`ifdef LFSR_CHK_PERIOD_EN
            tick_d = (in_word == anchor_q);
`endif
          end else begin
            err_hit = 1'b1;
            miss_d  = miss_q + 4'd1;
            if (miss_q + 4'd1 == 4'(LOSS_CNT)) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr) err_cnt_d = err_hit ? ERR_W'(1) : '0;
    else if (err_hit && err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      pred_q      <= 4'd0;
      run_q       <= 4'd0;
      miss_q      <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
`ifdef LFSR_CHK_PERIOD_EN
      anchor_q    <= 4'd0;
      tick_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= (state_d == LOCKED);
      err_pulse_q <= err_hit;
      err_cnt_q   <= err_cnt_d;
`ifdef LFSR_CHK_PERIOD_EN
      anchor_q    <= anchor_d;
      tick_q      <= tick_d;
`endif
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
`ifdef LFSR_CHK_PERIOD_EN
  assign period_tick = tick_q;
`endif

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 4-bit `lfsr` generator. It takes the generator's parallel output stream, locks onto its sequence, predicts every following word and counts mismatches. Benches and self-test paths use it to check generator output without a golden model. It sits directly on the generator's `out` bus.

## Interface
Parameters:
- `LOCK_CNT`, 3: consecutive correct predictions required to declare lock (range 1..15).
- `LOSS_CNT`, 2: consecutive mispredictions while locked that drop lock (range 1..15).
- `ERR_W`, 16: error counter width.

Ports:
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_word` is valid this cycle. Cycles with `in_valid` low change no state except `clr`.
- `in_word` input 4: received LFSR word.
- `clr` input 1: synchronous clear of `err_cnt`.
- `locked` output 1: the checker is in state LOCKED.
- `err_pulse` output 1: one-cycle pulse for each misprediction counted while locked.
- `err_cnt` output ERR_W: saturating count of mispredictions while locked.

## Operation
- Step function matches the generator (x^4+x^3+1, Fibonacci): `next(q) = {q[2:0], q[3]^q[2]}`. Period is 15. 0000 is illegal.
- Internal registers:
  - `pred[3:0]`: predicted next word.
  - `run[3:0]`: consecutive-match counter.
  - `miss[3:0]`: consecutive-miss counter.
  - `state`: one of HUNT, VERIFY, LOCKED.
- All transitions below occur only on cycles with `in_valid` high.
- HUNT (reset state):
  - Nonzero word: `pred <= next(in_word)`, `run <= 0`, go to VERIFY.
  - 0000: ignored, stay in HUNT.
- VERIFY:
  - Match (`in_word == pred`): `pred <= next(pred)`, `run <= run+1`. If `run+1 == LOCK_CNT`, go to LOCKED and set `miss <= 0`.
  - Mismatch, nonzero word: reseed with `pred <= next(in_word)`, `run <= 0`, stay in VERIFY.
  - Mismatch, word 0000: go to HUNT.
  - No errors are counted in VERIFY.
- LOCKED:
  - Match: `pred <= next(pred)`, `miss <= 0`.
  - Mismatch, flywheel behaviour:
    - `pred <= next(pred)`; the checker never reseeds from a bad word.
    - `err_cnt` increments, saturating at all-ones.
    - `err_pulse` asserts.
    - `miss <= miss+1`.
    - If `miss+1 == LOSS_CNT`, go to HUNT.
  - This final error is still counted on the transition to HUNT.
- `clr` and a counted error in the same cycle: `err_cnt <= 1`.
- `clr` never affects state, `pred` or lock.

## Timing
- Reset values: state HUNT, `pred` 0000, `run` 0, `miss` 0, `locked` 0, `err_pulse` 0, `err_cnt` 0.
- All outputs are registered. Each one reflects the valid word sampled on the previous edge.
- Lock latency:
  - `locked` rises on the edge that samples the (LOCK_CNT+1)-th valid word after the seed, counting the seed as word 1.
  - With default LOCK_CNT it rises after word 4.
- `err_pulse` and the `err_cnt` update appear on the edge that samples the bad word, for one cycle.
- `locked` falls on the same edge that counts the LOSS_CNT-th consecutive miss.
- Gaps with `in_valid` low are transparent. Prediction holds across them.
- Asserting `rst` mid-operation clears everything immediately, without waiting for `clk`. The first edge after release behaves as HUNT.

## Configuration
- `LFSR_CHK_PERIOD_EN` defined:
  - Adds output `period_tick` (1 bit, reset 0) and a 4-bit anchor register.
  - On entry to LOCKED the anchor captures that matched word.
  - While LOCKED, `period_tick` pulses for one cycle whenever a matching valid word equals the anchor, i.e. every 15 valid words.
  - The anchor is re-captured on every new lock.
- Not defined:
  - The port and the anchor logic are absent.
  - All other behaviour is identical.

## Test plan
- Lock: `rst` pulse, then valid words 1111, 1110, 1100, 1000 on consecutive cycles. Required: `locked` is 0 through word 3 and 1 after word 4; `err_cnt` = 0.
- Single error: lock as above, then feed 0000 in place of the expected 0001, followed by 0010. Required:
  - one `err_pulse`, `err_cnt` = 1;
  - `locked` stays 1, since the flywheel prediction matches 0010.
- Loss: while locked, feed two consecutive wrong nonzero words (e.g. 0101, 0101). Required: `err_cnt` +2 and `locked` = 0 after the second word. Then re-lock from 0011, 0110, 1101, 1010.
- Gaps and seeding:
  - Insert 3 cycles of `in_valid` low between every lock word; lock latency in valid words is unchanged.
  - 0000 in HUNT leaves the checker in HUNT.
- Clear collision: set ERR_W = 2 and force 5 errors (re-locking as needed). `err_cnt` saturates at 3. Then `clr` in the same cycle as an error gives `err_cnt` = 1.
- With `LFSR_CHK_PERIOD_EN`: drive the free-running generator from seed 1111 for 60 cycles. Required: `period_tick` pulses exactly every 15 valid words after lock, and `rst` mid-stream clears it to 0 immediately.
